// File: rtl/multicycle_control_unit_if.sv
// Memory-port / datapath-control bundle for the multicycle control unit.
//
// Handshake: the control unit raises mem_req and holds it, together with
// iord/MemRead/MemWrite, until the memory answers with mem_ready=1 in the
// same cycle. That cycle completes the transfer. mem_ready is ignored
// whenever mem_req is low.
//
// Signals:
//   opcode      : instr[6:0] from IR, sampled by the control unit in DECODE
//   mem_ready   : memory completes the current request this cycle
//   mem_req     : memory request, held until mem_ready
//   iord        : 0 = instruction address (PC), 1 = data address (ALU result)
//   pc_write    : PC <= PC+4
//   ir_write    : IR <= memory read data
//   ALUSrc      : 0 = rs2, 1 = immediate
//   MemToReg    : 1 = write-back from memory data
//   RegWrite    : register file write enable
//   MemRead     : memory read
//   MemWrite    : memory write
//   branch      : branch evaluation strobe
//   ALUOp       : 00 add, 01 branch compare, 10 R-type, 11 I-type
//   illegal     : sticky illegal-opcode trap flag
//   timeout     : sticky memory-timeout trap flag
//   state_dbg   : encoded FSM state
//   instr_count : retired-instruction counter
interface multicycle_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             pc_write;
    logic             ir_write;
    logic             ALUSrc;
    logic             MemToReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             branch;
    logic [1:0]       ALUOp;
    logic             illegal;
    logic             timeout;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    // Control unit side
    modport master (
        input  opcode, mem_ready,
        output mem_req, iord, pc_write, ir_write, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, branch, ALUOp, illegal, timeout, state_dbg,
               instr_count
    );

    // Memory / datapath side
    modport slave (
        output opcode, mem_ready,
        input  mem_req, iord, pc_write, ir_write, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, branch, ALUOp, illegal, timeout, state_dbg,
               instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared instruction/data memory, with illegal-opcode and memory-timeout
// traps and a retired-instruction counter.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : multicycle_control_unit_if.master (memory handshake, datapath
//         controls, trap flags, state_dbg, instr_count)
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT   = 15,
    parameter int CNT_W         = 16,
    parameter bit ENABLE_BRANCH = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH
    } cls_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state, state_n;
    cls_t             cls, cls_n, dec_cls;
    ctrl_t            ctrl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_q, timeout_q;
    logic             retire, set_illegal, set_timeout;
    logic             limit_hit;

    // Moore control decode; evaluated on the next state so the outputs
    // can be registered and line up with the state they belong to.
    function automatic ctrl_t ctrl_decode(input state_t st, input cls_t c);
        ctrl_t o;
        o = '0;
        case (st)
            FETCH: begin
                o.mem_req  = 1'b1;
                o.mem_read = 1'b1;
            end
            EXEC: begin
                case (c)
                    CLS_R:      o.alu_op = 2'b10;
                    CLS_I:      begin o.alu_src = 1'b1; o.alu_op = 2'b11; end
                    CLS_LOAD,
                    CLS_STORE:  o.alu_src = 1'b1;
                    CLS_BRANCH: begin o.alu_op = 2'b01; o.branch = 1'b1; end
                    default:    o = '0;
                endcase
            end
            MEM: begin
                o.mem_req   = 1'b1;
                o.iord      = 1'b1;
                o.alu_src   = 1'b1;
                o.mem_read  = (c == CLS_LOAD);
                o.mem_write = (c == CLS_STORE);
            end
            WB: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = (c == CLS_LOAD);
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        dec_cls = CLS_NONE;
        case (bus.opcode)
            7'b0110011: dec_cls = CLS_R;
            7'b0010011: dec_cls = CLS_I;
            7'b0000011: dec_cls = CLS_LOAD;
            7'b0100011: dec_cls = CLS_STORE;
            7'b1100011: dec_cls = ENABLE_BRANCH ? CLS_BRANCH : CLS_NONE;
            default:    dec_cls = CLS_NONE;
        endcase
    end

    // The wait counter holds the number of unanswered cycles already spent;
    // this cycle is the limit-th one when it equals MEM_TIMEOUT-1. A ready
    // in that same cycle is checked first, so it wins over the trap.
    assign limit_hit = (MEM_TIMEOUT != 0) &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_n     = state;
        cls_n       = cls;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (bus.mem_ready) begin
                    state_n = DECODE;
                end else if (limit_hit) begin
                    state_n     = TRAP;
                    set_timeout = 1'b1;
                end
            end
            DECODE: begin
                cls_n = dec_cls;
                if (dec_cls == CLS_NONE) begin
                    state_n     = TRAP;
                    set_illegal = 1'b1;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    CLS_R, CLS_I:        state_n = WB;
                    CLS_LOAD, CLS_STORE: state_n = MEM;
                    CLS_BRANCH: begin
                        state_n = FETCH;
                        retire  = 1'b1;
                    end
                    default:             state_n = TRAP;
                endcase
            end
            MEM: begin
                if (bus.mem_ready) begin
                    if (cls == CLS_LOAD) begin
                        state_n = WB;
                    end else begin
                        state_n = FETCH;
                        retire  = 1'b1;
                    end
                end else if (limit_hit) begin
                    state_n     = TRAP;
                    set_timeout = 1'b1;
                end
            end
            WB: begin
                state_n = FETCH;
                retire  = 1'b1;
            end
            TRAP:    state_n = TRAP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cls         <= CLS_NONE;
            ctrl_q      <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cls    <= cls_n;
            ctrl_q <= ctrl_decode(state_n, cls_n);
            // Any state change (entry to FETCH/MEM, completion, trap) clears it.
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if ((state == FETCH || state == MEM) && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
        end
    end

    assign bus.mem_req     = ctrl_q.mem_req;
    assign bus.iord        = ctrl_q.iord;
    assign bus.ALUSrc      = ctrl_q.alu_src;
    assign bus.MemToReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.branch      = ctrl_q.branch;
    assign bus.ALUOp       = ctrl_q.alu_op;
    // IR/PC load only in the cycle the fetch actually completes.
    assign bus.ir_write    = (state == FETCH) && bus.mem_ready;
    assign bus.pc_write    = (state == FETCH) && bus.mem_ready;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
    assign bus.state_dbg   = state;
    assign bus.instr_count = instr_count;
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequential successor to the single-cycle opcode decoder. It steps each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB using a shared instruction/data memory with a req/ready handshake. It drives the same datapath control set (ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, branch, ALUOp) plus PC/IR write enables. It sits between the memory port and the datapath, adding a memory timeout trap, illegal-opcode trap and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready in FETCH/MEM before trapping; 0 disables the timeout
CNT_W, 16, width of the retired-instruction counter
ENABLE_BRANCH, 1, 1 = opcode 1100011 is legal; 0 = it traps as illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  instr[6:0] from IR, sampled in DECODE
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
iord  out  1  0 = instruction address (PC), 1 = data address (ALU result)
pc_write  out  1  PC <= PC+4
ir_write  out  1  IR <= memory read data
ALUSrc  out  1  0 = rs2, 1 = immediate
MemToReg  out  1  1 = write-back from memory data
RegWrite  out  1  register file write enable
MemRead  out  1  memory read
MemWrite  out  1  memory write
branch  out  1  branch evaluation strobe (datapath gates with zero flag)
ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type
illegal  out  1  sticky: illegal opcode trap
timeout  out  1  sticky: memory timeout trap
state_dbg  out  3  encoded state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any time, including mid-memory-wait): state=IDLE, class latch=NONE, wait counter=0, instr_count=0, illegal=0, timeout=0. All control outputs are 0 while in IDLE.
- IDLE: one cycle after reset release, then FETCH.
- Outputs are a Moore decode of (state, latched class). The only exception is the ready-qualified pulses noted below.
- FETCH: mem_req=1, MemRead=1, iord=0. ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then go to DECODE. Otherwise stay.
- DECODE (1 cycle, all controls 0): latch class from opcode.
  - 0110011 R; 0010011 I; 0000011 LOAD; 0100011 STORE; 1100011 BRANCH (if ENABLE_BRANCH).
  - Legal opcode -> EXEC. Anything else -> TRAP with illegal=1.
  - Opcode changes after DECODE have no effect.
- EXEC:
  - R: ALUSrc=0, ALUOp=10 -> WB.
  - I: ALUSrc=1, ALUOp=11 -> WB.
  - LOAD/STORE: ALUSrc=1, ALUOp=00 -> MEM.
  - BRANCH: ALUSrc=0, ALUOp=01, branch=1 for this single cycle, instr_count+1 -> FETCH.
- MEM: mem_req=1, iord=1, ALUSrc=1, ALUOp=00. LOAD: MemRead=1. STORE: MemWrite=1. Exit when mem_ready=1:
  - LOAD -> WB.
  - STORE -> FETCH with instr_count+1.
- WB: RegWrite=1 for exactly 1 cycle; MemToReg=1 for LOAD only; instr_count+1 -> FETCH.
- Zero-wait latency (mem_ready high when requested): R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Each memory wait adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on mem_ready.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: next state TRAP, timeout=1.
  - mem_ready=1 in the same cycle the limit is reached wins; no trap.
- TRAP: absorbing until reset. All controls 0, mem_req=0, illegal/timeout held, instr_count frozen.
- mem_ready outside FETCH/MEM is ignored.
- instr_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Zero-wait R-type (opcode 0110011, mem_ready=1): states 1,2,3,5,1. RegWrite high 1 cycle, ALUOp=10, ALUSrc=0, MemToReg=0. instr_count 0->1 after 4 cycles.
- LOAD with 2 wait cycles in MEM: MEM held 3 cycles with MemRead=1, iord=1. Then WB with RegWrite=1, MemToReg=1. Total 7 cycles, count+1.
- STORE then BRANCH back-to-back (zero-wait): MemWrite=1 exactly 1 cycle, no RegWrite. branch=1 exactly 1 cycle with ALUOp=01. instr_count=2 after 7 cycles. With ENABLE_BRANCH=0 the branch gives TRAP, illegal=1.
- Illegal opcode 1111111: DECODE goes to TRAP, illegal=1, outputs 0. Subsequent mem_ready/opcode activity has no effect; rst returns to IDLE with flags clear.
- Timeout, MEM_TIMEOUT=3, mem_ready held 0 in FETCH: TRAP entered after 3 wait cycles, timeout=1. Repeat with mem_ready=1 on the 3rd wait cycle: no trap, DECODE follows.
- CNT_W=2, 5 R-type instructions: instr_count 1,2,3,0,1. Assert rst mid-FETCH wait: immediate IDLE, count 0, mem_req drops asynchronously.
